// File: rtl/logic_unit_pkg.sv
// Purpose : shared types and the per-bit gate function for the pipelined logic unit.
// Latency : n/a (package, no state).
// Backpressure: n/a.
// Contents: op_t (eight gate ops), OP_W, logic_eval(op, a, b) evaluated one bit at a
//           time so the caller sets the vector width by looping over WIDTH bits.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_BUF  = 3'd0,
        OP_NOT  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NAND = 3'd6,
        OP_NOR  = 3'd7
    } op_t;

    // Single-bit gate; all ops are bitwise, so a WIDTH-bit result is this
    // function applied to each bit position.
    function automatic logic logic_eval(op_t op, logic a, logic b);
        logic r;
        case (op)
            OP_BUF:  r = a;
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NAND: r = ~(a & b);
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Purpose : operand-in / result-out handshake bundle for logic_unit_pipe.
// Latency : n/a (wires only).
// Backpressure: in_ready / out_ready valid-ready pairs.
// Modports: master = operand source + result consumer side, slave = the unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_t              in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    op_t              out_op;
    logic [2:0]       out_red;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_op, out_red, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_op, out_red, out_count
    );

endinterface

// File: rtl/logic_unit_stage.sv
// Purpose : one valid/ready register slice with a W-bit payload.
// Latency : 1 cycle in to out.
// Backpressure: in_rdy = !out_vld | out_rdy; a held beat never changes while stalled.
// Ports   : clk, rst (async, active high), in_vld/in_rdy/in_dat upstream,
//           out_vld/out_rdy/out_dat downstream.
module logic_unit_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    // Slot is free when empty or its current beat leaves on this edge.
    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Purpose : two-stage pipelined WIDTH-bit bitwise logic unit (8 gate ops) with result counter.
// Latency : 2 cycles input transfer to out_valid; 1 beat/cycle with out_ready high.
// Backpressure: S2 holds while out_ready low; in_ready drops once both stages are full.
// Ports   : clk, rst (async, active high), bus (logic_unit_pipe_if.slave).
// Build option: LOGIC_UNIT_REDUCE_EN registers {^, |, &} of the result on out_red;
//               without it out_red is constant zero.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    logic_unit_pipe_if.slave   bus
);

    localparam int S1_W = 2*WIDTH + OP_W;
`ifdef LOGIC_UNIT_REDUCE_EN
    localparam int S2_W = WIDTH + OP_W + 3;
`else
    localparam int S2_W = WIDTH + OP_W;
`endif

    logic             v1;
    logic             s1_rdy;
    logic [S1_W-1:0]  s1_dat;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_t              s1_op;
    logic [WIDTH-1:0] result;

    logic             v2;
    logic             s2_rdy;
    logic [S2_W-1:0]  s2_in;
    logic [S2_W-1:0]  s2_dat;

    // Stage 1: capture raw operands and op.
    logic_unit_stage #(.W(S1_W)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (bus.in_valid),
        .in_rdy  (s1_rdy),
        .in_dat  ({bus.in_a, bus.in_b, bus.in_op}),
        .out_vld (v1),
        .out_rdy (s2_rdy),
        .out_dat (s1_dat)
    );

    assign bus.in_ready = s1_rdy;
    assign s1_a  = s1_dat[S1_W-1 -: WIDTH];
    assign s1_b  = s1_dat[OP_W +: WIDTH];
    assign s1_op = op_t'(s1_dat[OP_W-1:0]);

    always_comb begin
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            result[i] = logic_eval(s1_op, s1_a[i], s1_b[i]);
        end
    end

`ifdef LOGIC_UNIT_REDUCE_EN
    // Reductions taken from the very result vector that goes into out_data.
    assign s2_in = {result, s1_op, ^result, |result, &result};
`else
    assign s2_in = {result, s1_op};
`endif

    // Stage 2: registered result, op and (optionally) reductions.
    logic_unit_stage #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (v1),
        .in_rdy  (s2_rdy),
        .in_dat  (s2_in),
        .out_vld (v2),
        .out_rdy (bus.out_ready),
        .out_dat (s2_dat)
    );

    assign bus.out_valid = v2;
    assign bus.out_data  = s2_dat[S2_W-1 -: WIDTH];
`ifdef LOGIC_UNIT_REDUCE_EN
    assign bus.out_op    = op_t'(s2_dat[3 +: OP_W]);
    assign bus.out_red   = s2_dat[2:0];
`else
    assign bus.out_op    = op_t'(s2_dat[OP_W-1:0]);
    assign bus.out_red   = 3'b000;
`endif

    // Counts consumer-side transfers; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_count <= '0;
        end else if (v2 && bus.out_ready) begin
            bus.out_count <= bus.out_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Purpose : self-checking bench for logic_unit_pipe (directed table + random vs queue model).
// Latency : n/a.
// Backpressure: exercised via directed stall sequence and random out_ready.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int CWS = 2;
`ifdef LOGIC_UNIT_REDUCE_EN
    localparam bit RED_EN = 1'b1;
`else
    localparam bit RED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(W), .CNT_W(CW))  bus ();
    logic_unit_pipe_if #(.WIDTH(W), .CNT_W(CWS)) bus_s ();

    // Second unit with a 2-bit counter sees identical stimulus, for wrap checks.
    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in_a      = bus.in_a;
    assign bus_s.in_b      = bus.in_b;
    assign bus_s.in_op     = bus.in_op;
    assign bus_s.out_ready = bus.out_ready;

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW))  dut   (.clk(clk), .rst(rst), .bus(bus.slave));
    logic_unit_pipe #(.WIDTH(W), .CNT_W(CWS)) dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_eval(op_t op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            OP_BUF:  return a;
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_XNOR: return ~(a ^ b);
            OP_NAND: return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic [2:0] ref_red(logic [W-1:0] r);
        return RED_EN ? {^r, |r, &r} : 3'b000;
    endfunction

    function automatic logic [2:0] red_if(logic [2:0] x);
        return RED_EN ? x : 3'b000;
    endfunction

    typedef struct {
        op_t          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic [2:0]   r;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        op_t          op;
        logic [2:0]   r;
        int           acc;
    } beat_t;

    task automatic drive(input logic v, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, OP_BUF, '0, '0);
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        vec_t  tab [11];
        beat_t q [$];
        beat_t hd;
        logic [W-1:0] bp_a [3];
        logic [W-1:0] bp_b [3];
        op_t          bp_op [3];
        logic [W-1:0] got [$];
        int           wrap_exp [5];
        int           rdy_pct [6];
        int           accepted;
        int           cyc;
        logic [CW-1:0] mcount;
        logic         exp_valid, exp_rdy, in_fire, out_fire;

        tab[0]  = '{OP_BUF,  8'hA5, 8'h3C, 8'hA5, red_if(3'b010)};
        tab[1]  = '{OP_NOT,  8'hA5, 8'h3C, 8'h5A, red_if(3'b010)};
        tab[2]  = '{OP_AND,  8'hA5, 8'h3C, 8'h24, red_if(3'b010)};
        tab[3]  = '{OP_OR,   8'hA5, 8'h3C, 8'hBD, red_if(3'b010)};
        tab[4]  = '{OP_XOR,  8'hA5, 8'h3C, 8'h99, red_if(3'b010)};
        tab[5]  = '{OP_XNOR, 8'hA5, 8'h3C, 8'h66, red_if(3'b010)};
        tab[6]  = '{OP_NAND, 8'hA5, 8'h3C, 8'hDB, red_if(3'b010)};
        tab[7]  = '{OP_NOR,  8'hA5, 8'h3C, 8'h42, red_if(3'b010)};
        tab[8]  = '{OP_AND,  8'hFF, 8'hFF, 8'hFF, red_if(3'b011)};
        tab[9]  = '{OP_XOR,  8'h0F, 8'h0F, 8'h00, red_if(3'b000)};
        tab[10] = '{OP_NOT,  8'h7F, 8'h00, 8'h80, red_if(3'b110)};
        wrap_exp = '{1, 2, 3, 0, 1};
        rdy_pct  = '{90, 50, 10, 100, 30, 70};

        drive(1'b0, OP_BUF, '0, '0);
        bus.out_ready = 1'b0;

        // ---- reset release, idle inputs ----
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_count", 32'(bus.out_count), 32'd0);
            next_cycle();
        end
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_op",   32'(bus.out_op),   32'd0);
        chk("rst_out_red",  32'(bus.out_red),  32'd0);

        // ---- table stream, one beat per cycle, out_ready high ----
        bus.out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c < 11) drive(1'b1, tab[c].op, tab[c].a, tab[c].b);
            else        drive(1'b0, OP_BUF, '0, '0);
            @(negedge clk);
            chk("tab_in_ready", 32'(bus.in_ready), 32'd1);
            if (c >= 2) begin
                chk("tab_out_valid", 32'(bus.out_valid), 32'd1);
                chk("tab_out_data",  32'(bus.out_data),  32'(tab[c-2].d));
                chk("tab_out_op",    32'(bus.out_op),    32'(tab[c-2].op));
                chk("tab_out_red",   32'(bus.out_red),   32'(tab[c-2].r));
            end else begin
                chk("tab_fill_valid", 32'(bus.out_valid), 32'd0);
            end
            if (c == 10) chk("tab_count8", 32'(bus.out_count), 32'd8);
            next_cycle();
        end
        @(negedge clk);
        chk("tab_drained_valid", 32'(bus.out_valid),   32'd0);
        chk("tab_count_end",     32'(bus.out_count),   32'd11);
        chk("tab_count_small",   32'(bus_s.out_count), 32'd3);
        next_cycle();

        // ---- backpressure: 3 beats offered with out_ready low ----
        do_reset();
        bp_op = '{OP_XOR, OP_NAND, OP_OR};
        bp_a  = '{8'h0F, 8'hC3, 8'h11};
        bp_b  = '{8'hF0, 8'h0F, 8'h22};
        accepted = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, bp_op[accepted], bp_a[accepted], bp_b[accepted]);
            @(negedge clk);
            if (c >= 2) begin
                chk("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
                chk("bp_out_valid",    32'(bus.out_valid), 32'd1);
                chk("bp_hold_data",    32'(bus.out_data),  32'(ref_eval(bp_op[0], bp_a[0], bp_b[0])));
            end
            if (bus.in_valid && bus.in_ready) accepted++;
            next_cycle();
        end
        chk("bp_accepted", 32'(accepted), 32'd2);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (accepted < 3) drive(1'b1, bp_op[2], bp_a[2], bp_b[2]);
            else              drive(1'b0, OP_BUF, '0, '0);
            @(negedge clk);
            if (c == 0) chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
            if (bus.in_valid && bus.in_ready) accepted++;
            if (bus.out_valid) got.push_back(bus.out_data);
            next_cycle();
        end
        chk("bp_accepted_all", 32'(accepted), 32'd3);
        chk("bp_drain_n", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("bp_drain_order", 32'(got[i]), 32'(ref_eval(bp_op[i], bp_a[i], bp_b[i])));
        chk("bp_count", 32'(bus.out_count), 32'd3);

        // ---- counter wrap on the 2-bit counter instance ----
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 5) drive(1'b1, OP_XOR, 8'(c), 8'hFF);
            else       drive(1'b0, OP_BUF, '0, '0);
            @(negedge clk);
            if (c >= 3) begin
                chk("wrap_small", 32'(bus_s.out_count), 32'(wrap_exp[c-3]));
                chk("wrap_main",  32'(bus.out_count),   32'(c-2));
            end
            next_cycle();
        end

        // ---- asynchronous reset with two beats in flight ----
        do_reset();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c < 2) drive(1'b1, OP_OR, 8'h81, 8'h18);
            else       drive(1'b0, OP_BUF, '0, '0);
            @(negedge clk);
            next_cycle();
        end
        @(negedge clk);
        chk("mid_full_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_full_rdy",   32'(bus.in_ready),  32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_rdy",   32'(bus.in_ready),  32'd1);
        next_cycle();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mid_post_valid", 32'(bus.out_valid), 32'd0);
            chk("mid_post_count", 32'(bus.out_count), 32'd0);
            next_cycle();
        end

        // ---- random traffic against a queue model ----
        do_reset();
        q.delete();
        cyc    = 0;
        mcount = '0;
        for (int blk = 0; blk < 6; blk++) begin
            for (int k = 0; k < 400; k++) begin
                drive($urandom_range(0, 3) != 0, op_t'($urandom_range(0, 7)),
                      W'($urandom), W'($urandom));
                bus.out_ready = ($urandom_range(0, 99) < rdy_pct[blk]);
                @(negedge clk);
                // A beat is visible two cycles after its input cycle unless an older beat blocks it.
                exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
                exp_rdy   = (q.size() < 2) || bus.out_ready;
                chk("rnd_out_valid", 32'(bus.out_valid),   32'(exp_valid));
                chk("rnd_in_ready",  32'(bus.in_ready),    32'(exp_rdy));
                chk("rnd_count",     32'(bus.out_count),   32'(mcount));
                chk("rnd_count_s",   32'(bus_s.out_count), 32'(mcount[CWS-1:0]));
                if (exp_valid) begin
                    hd = q[0];
                    chk("rnd_data", 32'(bus.out_data), 32'(hd.d));
                    chk("rnd_op",   32'(bus.out_op),   32'(hd.op));
                    chk("rnd_red",  32'(bus.out_red),  32'(hd.r));
                end
                in_fire  = bus.in_valid && exp_rdy;
                out_fire = exp_valid && bus.out_ready;
                @(posedge clk);
                if (out_fire) begin
                    void'(q.pop_front());
                    mcount = mcount + 1'b1;
                end
                if (in_fire) begin
                    hd.d   = ref_eval(bus.in_op, bus.in_a, bus.in_b);
                    hd.op  = bus.in_op;
                    hd.r   = ref_red(hd.d);
                    hd.acc = cyc;
                    q.push_back(hd);
                end
                cyc++;
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
